// File: rtl/button_conditioner.sv
// Pushbutton front end: two-flop synchroniser, debounce FSM, press pulse and clean level per button.
// Optional sel auto-repeat while held is compiled in with `define BUTTON_CONDITIONER_AUTOREPEAT_EN.

module button_channel #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 0          // 0 disables auto-repeat for this channel
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        RELEASED    = 2'd0,
        PRESS_CHK   = 2'd1,
        HELD        = 2'd2,
        RELEASE_CHK = 2'd3
    } state_t;

    logic [1:0]    sync_r;
    logic          s_s;
    state_t        state_r;
    state_t        state_n;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_n;
    logic          level_r;
    logic          level_n;
    logic          pulse_r;
    logic          press_s;
    logic          rpt_fire_s;

    assign s_s = sync_r[1];

    // Two-flop synchroniser for the asynchronous button input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // Debounce FSM: next state, qualification counter and level
    always_comb begin
        state_n = state_r;
        cnt_n   = cnt_r;
        level_n = level_r;
        press_s = 1'b0;
        case (state_r)
            RELEASED: begin
                if (s_s) begin
                    state_n = PRESS_CHK;
                    cnt_n   = '0;
                end else begin
                    state_n = RELEASED;
                end
            end
            PRESS_CHK: begin
                if (!s_s) begin
                    state_n = RELEASED;
                end else if (cnt_r == CNT_MAX) begin
                    state_n = HELD;
                    press_s = 1'b1;
                    level_n = 1'b1;
                end else begin
                    cnt_n = cnt_r + CW'(1'b1);
                end
            end
            HELD: begin
                if (!s_s) begin
                    state_n = RELEASE_CHK;
                    cnt_n   = '0;
                end else begin
                    state_n = HELD;
                end
            end
            RELEASE_CHK: begin
                if (s_s) begin
                    state_n = HELD;
                end else if (cnt_r == CNT_MAX) begin
                    state_n = RELEASED;
                    level_n = 1'b0;
                end else begin
                    cnt_n = cnt_r + CW'(1'b1);
                end
            end
            default: begin
                state_n = RELEASED;
                cnt_n   = '0;
                level_n = 1'b0;
            end
        endcase
    end

    // FSM, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RELEASED;
            cnt_r   <= '0;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            state_r <= state_n;
            cnt_r   <= cnt_n;
            level_r <= level_n;
            pulse_r <= press_s | rpt_fire_s;
        end
    end

    generate
        if (REPEAT_CYCLES >= 2) begin : g_repeat
            localparam int RW = $clog2(REPEAT_CYCLES);
            localparam logic [RW-1:0] RPT_MAX = RW'(REPEAT_CYCLES - 1);
            logic [RW-1:0] rcnt_r;
            logic          stay_held_s;

            assign stay_held_s = (state_r == HELD) && (state_n == HELD);
            assign rpt_fire_s  = stay_held_s && (rcnt_r == RPT_MAX);

            // Repeat timer: cleared on acceptance, runs in HELD, frozen elsewhere
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rcnt_r <= '0;
                end else if (press_s) begin
                    rcnt_r <= '0;
                end else if (stay_held_s) begin
                    rcnt_r <= rpt_fire_s ? '0 : rcnt_r + RW'(1'b1);
                end else begin
                    rcnt_r <= rcnt_r;
                end
            end
        end else begin : g_no_repeat
            assign rpt_fire_s = 1'b0;
        end
    endgenerate

    assign pulse = pulse_r;
    assign level = level_r;

endmodule

module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_CYCLES   = 50000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sel_raw,
    input  logic conf_raw,
    output logic sel_pulse,
    output logic conf_pulse,
    output logic sel_level,
    output logic conf_level
);

`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
    localparam int SEL_REPEAT = REPEAT_CYCLES;
`else
    localparam int SEL_REPEAT = 0 * REPEAT_CYCLES;
`endif

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (SEL_REPEAT)
    ) u_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (sel_raw),
        .pulse (sel_pulse),
        .level (sel_level)
    );

    // confirm never auto-repeats
    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .REPEAT_CYCLES   (0)
    ) u_conf (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (conf_raw),
        .pulse (conf_pulse),
        .level (conf_level)
    );

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8.

module tb_button_conditioner;

    logic clk;
    logic rst_n;
    logic sel_raw;
    logic conf_raw;
    logic sel_pulse;
    logic conf_pulse;
    logic sel_level;
    logic conf_level;

    int errors;
    int checks;

    button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_CYCLES   (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_raw    (sel_raw),
        .conf_raw   (conf_raw),
        .sel_pulse  (sel_pulse),
        .conf_pulse (conf_pulse),
        .sel_level  (sel_level),
        .conf_level (conf_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel_raw = 1'b0; conf_raw = 1'b0;
        #1;
        checks++;
        if ({sel_pulse, conf_pulse, sel_level, conf_level} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs got=%b exp=0000", {sel_pulse, conf_pulse, sel_level, conf_level});
        end
        idle(3);
        rst_n = 1'b1;
        idle(3);
        checks++;
        if ({sel_pulse, conf_pulse, sel_level, conf_level} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset got=%b exp=0000", {sel_pulse, conf_pulse, sel_level, conf_level});
        end
    endtask

    task automatic test_clean_press();
        sel_raw = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (sel_pulse !== (i == 7) || sel_level !== (i >= 7)) begin
                errors++;
                $display("FAIL clean_press edge=%0d got pulse=%b level=%b exp pulse=%b level=%b",
                         i, sel_pulse, sel_level, (i == 7), (i >= 7));
            end
            checks++;
            if (conf_pulse !== 1'b0 || conf_level !== 1'b0) begin
                errors++;
                $display("FAIL clean_press_conf edge=%0d got pulse=%b level=%b exp 0 0", i, conf_pulse, conf_level);
            end
        end
        sel_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (sel_level !== (i < 7) || sel_pulse !== 1'b0) begin
                errors++;
                $display("FAIL clean_release edge=%0d got level=%b pulse=%b exp level=%b pulse=0",
                         i, sel_level, sel_pulse, (i < 7));
            end
        end
    endtask

    task automatic test_bounce();
        logic [7:0] pat;
        pat = 8'b11001100;
        for (int i = 7; i >= 0; i--) begin
            sel_raw = pat[i];
            tick();
            checks++;
            if (sel_pulse !== 1'b0 || sel_level !== 1'b0) begin
                errors++;
                $display("FAIL bounce_quiet step=%0d got pulse=%b level=%b exp 0 0", 7 - i, sel_pulse, sel_level);
            end
        end
        sel_raw = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick();
            checks++;
            if (sel_pulse !== (i == 7)) begin
                errors++;
                $display("FAIL bounce_pulse edge=%0d got=%b exp=%b", i, sel_pulse, (i == 7));
            end
        end
        sel_raw = 1'b0;
        idle(8);
        checks++;
        if (sel_level !== 1'b0) begin
            errors++;
            $display("FAIL bounce_release_level got=%b exp=0", sel_level);
        end
    endtask

    task automatic test_release_glitch();
        sel_raw = 1'b1;
        idle(8);
        sel_raw = 1'b0;
        idle(2);
        sel_raw = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            checks++;
            if (sel_level !== 1'b1 || sel_pulse !== 1'b0) begin
                errors++;
                $display("FAIL glitch_hold edge=%0d got level=%b pulse=%b exp level=1 pulse=0", i, sel_level, sel_pulse);
            end
        end
        sel_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (sel_level !== (i < 7) || sel_pulse !== 1'b0) begin
                errors++;
                $display("FAIL glitch_release edge=%0d got level=%b pulse=%b exp level=%b pulse=0",
                         i, sel_level, sel_pulse, (i < 7));
            end
        end
    endtask

    task automatic test_simultaneous();
        sel_raw = 1'b1;
        conf_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (sel_pulse !== (i == 7) || conf_pulse !== (i == 7)) begin
                errors++;
                $display("FAIL simultaneous edge=%0d got sel=%b conf=%b exp both=%b", i, sel_pulse, conf_pulse, (i == 7));
            end
        end
        checks++;
        if (sel_level !== 1'b1 || conf_level !== 1'b1) begin
            errors++;
            $display("FAIL simultaneous_levels got sel=%b conf=%b exp 1 1", sel_level, conf_level);
        end
        sel_raw = 1'b0;
        conf_raw = 1'b0;
        idle(8);
        checks++;
        if (sel_level !== 1'b0 || conf_level !== 1'b0) begin
            errors++;
            $display("FAIL simultaneous_release got sel=%b conf=%b exp 0 0", sel_level, conf_level);
        end
    endtask

    task automatic test_reset_mid_hold();
        sel_raw = 1'b1;
        idle(9);
        rst_n = 1'b0;
        #1;
        checks++;
        if (sel_level !== 1'b0 || sel_pulse !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_hold got level=%b pulse=%b exp 0 0", sel_level, sel_pulse);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (sel_pulse !== (i == 7) || sel_level !== (i >= 7)) begin
                errors++;
                $display("FAIL reset_requalify edge=%0d got pulse=%b level=%b exp pulse=%b level=%b",
                         i, sel_pulse, sel_level, (i == 7), (i >= 7));
            end
        end
        sel_raw = 1'b0;
        idle(8);
    endtask

    task automatic test_hold_repeat();
        logic exp_p;
        sel_raw = 1'b1;
        for (int i = 1; i <= 37; i++) begin
            tick();
`ifdef BUTTON_CONDITIONER_AUTOREPEAT_EN
            exp_p = (i == 7) || (i > 7 && ((i - 7) % 8) == 0);
`else
            exp_p = (i == 7);
`endif
            checks++;
            if (sel_pulse !== exp_p) begin
                errors++;
                $display("FAIL sel_hold_repeat edge=%0d got=%b exp=%b", i, sel_pulse, exp_p);
            end
        end
        sel_raw = 1'b0;
        idle(8);
        conf_raw = 1'b1;
        for (int i = 1; i <= 37; i++) begin
            tick();
            checks++;
            if (conf_pulse !== (i == 7)) begin
                errors++;
                $display("FAIL conf_hold_single edge=%0d got=%b exp=%b", i, conf_pulse, (i == 7));
            end
        end
        conf_raw = 1'b0;
        idle(8);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_glitch();
        test_simultaneous();
        test_reset_mid_hold();
        test_hold_repeat();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end conditioning stage for the lab4 move-entry logic. It takes the raw `sel` and `conf` pushbutton inputs and synchronises each to `clk`. It then debounces each input and emits clean single-cycle press pulses plus debounced levels. These outputs drive the `sel`/`conf` inputs of the downstream move-selection block, so that block sees exactly one event per physical press.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive stable synchronised-sample clocks required to accept a press or a release (10 ms at 100 MHz); legal range >= 2.
- REPEAT_CYCLES, 50000000, hold time between auto-repeat pulses on sel; used only when the optional feature is compiled in; legal range >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sel_raw  input  1  raw select button, asynchronous to clk, active-high
- conf_raw  input  1  raw confirm button, asynchronous to clk, active-high
- sel_pulse  output  1  one-cycle pulse per accepted sel press
- conf_pulse  output  1  one-cycle pulse per accepted conf press
- sel_level  output  1  debounced sel level
- conf_level  output  1  debounced conf level

Behaviour:
- Decided: one clock `clk`; reset `rst_n` is asynchronous, active-low. All flops clear immediately on rst_n=0. Release is used synchronously; no special deassertion handling inside the block.
- Reset values:
  - all outputs 0
  - both synchronisers 0
  - both FSMs RELEASED
  - all counters 0
- Per channel:
  - Two-flop synchroniser on the raw input; the FSM uses only the second flop (s).
  - Debounce counter sized internally to hold DEBOUNCE_CYCLES-1.
- Per-channel FSM:
  - RELEASED: s=1 -> PRESS_CHK, cnt<=0. Otherwise stay.
  - PRESS_CHK: s=0 -> RELEASED (glitch rejected, no pulse). s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, pulse<=1 for one cycle, level<=1. Otherwise cnt<=cnt+1.
  - HELD: s=0 -> RELEASE_CHK, cnt<=0. Otherwise stay; level stays 1.
  - RELEASE_CHK: s=1 -> HELD (bounce on release, no new pulse). s=0 and cnt==DEBOUNCE_CYCLES-1 -> RELEASED, level<=0. Otherwise cnt<=cnt+1.
- Latency: raw input sampled high at clock edge 1 and held stable -> pulse is high during the cycle following edge DEBOUNCE_CYCLES+3. Release latency to level=0 is likewise DEBOUNCE_CYCLES+3 edges.
- Pulse width is exactly one clk cycle. Never two pulses per press, unless auto-repeat is enabled.
- Channels are fully independent:
  - simultaneous presses may produce sel_pulse and conf_pulse in the same cycle;
  - no priority or masking between channels.
- Any input toggle before the counter completes restarts qualification from RELEASED (press) or HELD (release).
- Reset mid-qualification or mid-hold:
  - state returns to RELEASED, levels drop to 0, no pulse;
  - a button still held after reset release is re-qualified and produces one new pulse.

Optional Feature:
- Macro: BUTTON_CONDITIONER_AUTOREPEAT_EN.
- Defined:
  - the sel channel keeps a repeat counter that runs while in HELD and clears on entry to HELD;
  - each time it reaches REPEAT_CYCLES-1, sel_pulse asserts for one cycle and the counter restarts;
  - leaving HELD stops repeats; RELEASE_CHK pauses and does not clear the counter; RELEASE_CHK->HELD resumes counting;
  - conf never repeats.
- Undefined: no repeat counter is instantiated; exactly one sel_pulse per accepted press.

Test Plan:
- Reset, then DEBOUNCE_CYCLES=4 and a clean sel_raw rise at edge 1, held -> sel_pulse=1 only in the cycle after edge 7. sel_level=1 from then on. conf outputs stay 0.
- sel_raw bounces 1,0,1,0 each 2 cycles, then stays 1 (DEBOUNCE_CYCLES=4) -> exactly one sel_pulse, 7 edges after the final rising sample; no pulse during the bounce.
- Held sel, then a 2-cycle low glitch, then high again -> no second pulse and sel_level never drops. A sustained low then gives sel_level=0, 7 edges after the low began.
- sel_raw and conf_raw rise on the same edge -> sel_pulse and conf_pulse assert together in the same cycle.
- rst_n pulsed low for 1 cycle while sel is held in HELD -> sel_level=0 immediately. With sel still high, a new sel_pulse follows 7 edges after rst_n release.
- AUTOREPEAT_EN defined, REPEAT_CYCLES=8, sel held 30 cycles past acceptance -> initial pulse plus pulses every 8 cycles (3 repeats). Holding conf gives a single pulse.
